round_judge: RTL and testbench

Round front-end of the arcade cabinet. It captures one player move from the three move buttons and runs a reveal countdown. It then draws a pseudo-random machine move, judges the round, and drives the 2-bit result code consumed by `consecutive_win` (00 lose, 01 draw, 11 win). Between verdicts `result` idles at 01, the draw/no-op code, so the downstream FSM holds state every clock except the single verdict cycle.

---
 rtl/round_judge_if.sv | 20 ++
 rtl/round_judge.sv | 100 ++++++++++
 tb/tb_round_judge.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/round_judge_if.sv
// round_judge_if: button, game-status and verdict bundle between the cabinet and round_judge.
interface round_judge_if;
    logic       btn_rock;
    logic       btn_paper;
    logic       btn_scissors;
    logic       game_active;
    logic [1:0] result;
    logic       result_valid;
    logic [1:0] player_move;
    logic [1:0] machine_move;
    logic       busy;
    modport master (
        output btn_rock, btn_paper, btn_scissors, game_active,
        input  result, result_valid, player_move, machine_move, busy
    );
    modport slave (
        input  btn_rock, btn_paper, btn_scissors, game_active,
        output result, result_valid, player_move, machine_move, busy
    );
endinterface

// File: rtl/round_judge.sv
// round_judge: captures a player move, runs the reveal countdown, draws an LFSR machine move and judges.
// Defining ROUND_JUDGE_BTN_SYNC_EN adds 2-flop button synchronizers ahead of edge detection.
module round_judge #(
    parameter logic [15:0] REVEAL_CYCLES = 16'd4,
    parameter logic [7:0]  LFSR_SEED     = 8'h01
) (
    input logic          clk,
    input logic          reset,
    round_judge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REVEAL, JUDGE} state_t;
    state_t      state, state_nx;
    logic [7:0]  lfsr;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  btn, hist, rise;
    logic        accept;
    logic [1:0]  press_move, draw, win_move, verdict;
    logic [1:0]  result, result_nx, player_move, player_nx, machine_move, machine_nx;
    logic        result_valid, valid_nx, busy;
`ifdef ROUND_JUDGE_BTN_SYNC_EN
    logic [2:0] sync1, sync2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.btn_scissors, bus.btn_paper, bus.btn_rock};
            sync2 <= sync1;
        end
    end
    assign btn = sync2;
`else
    assign btn = {bus.btn_scissors, bus.btn_paper, bus.btn_rock};
`endif
    // a press counts only as a lone rising edge with every other button released
    assign rise       = btn & ~hist;
    assign accept     = $onehot(rise) && btn == rise;
    assign press_move = rise[0] ? 2'd1 : rise[1] ? 2'd2 : 2'd3;
    assign draw       = lfsr[1:0] != 2'd3 ? lfsr[1:0] + 2'd1 :
                        lfsr[3:2] != 2'd3 ? lfsr[3:2] + 2'd1 : 2'd1;
    assign win_move   = machine_move == 2'd3 ? 2'd1 : machine_move + 2'd1;
    assign verdict    = player_move == win_move ? 2'b11 :
                        player_move == machine_move ? 2'b01 : 2'b00;
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        player_nx  = player_move;
        machine_nx = machine_move;
        result_nx  = 2'b01;
        valid_nx   = 1'b0;
        if (state != IDLE && !bus.game_active) begin
            state_nx = IDLE;
        end else if (state == IDLE) begin
            if (accept && bus.game_active) begin
                state_nx   = REVEAL;
                player_nx  = press_move;
                machine_nx = 2'd0;
                cnt_nx     = REVEAL_CYCLES - 16'd1;
            end
        end else if (state == REVEAL) begin
            cnt_nx = cnt - 16'd1;
            if (cnt == 16'd0) begin
                state_nx   = JUDGE;
                machine_nx = draw;
            end
        end else begin
            state_nx  = IDLE;
            result_nx = verdict;
            valid_nx  = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lfsr         <= LFSR_SEED;
            hist         <= '0;
            result       <= 2'b01;
            result_valid <= 1'b0;
            player_move  <= 2'd0;
            machine_move <= 2'd0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            hist         <= btn;
            result       <= result_nx;
            result_valid <= valid_nx;
            player_move  <= player_nx;
            machine_move <= machine_nx;
            busy         <= state_nx != IDLE;
        end
    end
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.player_move  = player_move;
    assign bus.machine_move = machine_move;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: directed self-checking bench for round_judge with REVEAL_CYCLES=4, LFSR_SEED=8'h01.
module tb_round_judge;
    localparam int RC = 4;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    logic [7:0] m_lfsr;
    round_judge_if bus ();
    round_judge #(.REVEAL_CYCLES(16'd4), .LFSR_SEED(8'h01)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // independent LFSR model, used to predict each machine draw ahead of time
    always @(posedge clk or negedge reset)
        if (!reset) m_lfsr <= 8'h01;
        else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction
    function automatic logic [1:0] move_of(input logic [7:0] q);
        case (q[1:0])
            2'd0: return 2'd1;
            2'd1: return 2'd2;
            2'd2: return 2'd3;
            default: case (q[3:2])
                2'd0: return 2'd1;
                2'd1: return 2'd2;
                2'd2: return 2'd3;
                default: return 2'd1;
            endcase
        endcase
    endfunction
    function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] m);
        if (p == m) return 2'b01;
        if ({p, m} == 4'b10_01 || {p, m} == 4'b11_10 || {p, m} == 4'b01_11) return 2'b11;
        return 2'b00;
    endfunction
    function automatic logic [1:0] predict();
        logic [7:0] l = m_lfsr;
        for (int i = 0; i < RC; i++) l = lfsr_step(l);
        return move_of(l);
    endfunction
    task automatic set_btn(input logic [2:0] b);
        bus.btn_rock     = b[0];
        bus.btn_paper    = b[1];
        bus.btn_scissors = b[2];
    endtask
    // starts at a falling edge with the DUT idle; press is sampled on the next rising edge (E0)
    task automatic run_round(input logic [1:0] p, input string tag);
        logic [1:0] m, mm_seen, pm_seen, res_seen;
        int busy_n, rv_n, rv_k, idle_bad;
        m = predict();
        set_btn(3'b001 << (p - 2'd1));
        busy_n = 0; rv_n = 0; rv_k = -1; idle_bad = 0;
        mm_seen = 2'd0; pm_seen = 2'd0; res_seen = 2'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_btn(3'b000);
            if (bus.busy) busy_n++;
            if (bus.result_valid) begin
                rv_n++;
                rv_k = k;
                mm_seen = bus.machine_move;
                pm_seen = bus.player_move;
                res_seen = bus.result;
            end else if (bus.result !== 2'b01) idle_bad++;
        end
        checks += 7;
        if (busy_n != RC + 1) begin failures++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_n, RC + 1); end
        if (rv_n != 1) begin failures++; $display("FAIL %s valid_pulses: got %0d want 1", tag, rv_n); end
        if (rv_k != RC + 1) begin failures++; $display("FAIL %s valid_latency: got %0d want %0d", tag, rv_k, RC + 1); end
        if (pm_seen !== p) begin failures++; $display("FAIL %s player_move: got %0d want %0d", tag, pm_seen, p); end
        if (mm_seen !== m) begin failures++; $display("FAIL %s machine_move: got %0d want %0d", tag, mm_seen, m); end
        if (res_seen !== judge(p, m)) begin failures++; $display("FAIL %s result: got %b want %b", tag, res_seen, judge(p, m)); end
        if (idle_bad != 0) begin failures++; $display("FAIL %s idle_result: got %0d non-01 cycles want 0", tag, idle_bad); end
    endtask
    task automatic test_reset();
        @(negedge clk);
        checks += 5;
        if (bus.result !== 2'b01) begin failures++; $display("FAIL reset result: got %b want 01", bus.result); end
        if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL reset result_valid: got %b want 0", bus.result_valid); end
        if (bus.player_move !== 2'd0) begin failures++; $display("FAIL reset player_move: got %b want 00", bus.player_move); end
        if (bus.machine_move !== 2'd0) begin failures++; $display("FAIL reset machine_move: got %b want 00", bus.machine_move); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    endtask
    task automatic test_lfsr();
        logic [7:0] e [7];
        e = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (dut.lfsr !== e[i]) begin failures++; $display("FAIL lfsr edge%0d: got %h want %h", i + 1, dut.lfsr, e[i]); end
        end
    endtask
    task automatic test_single_round();
        run_round(2'd1, "single_rock");
    endtask
    task automatic test_judge_coverage();
        bit cov [9];
        int covered;
        logic [1:0] m, p;
        covered = 0;
        for (int r = 0; r < 40 && covered < 9; r++) begin
            m = predict();
            p = 2'd1;
            for (int q = 3; q >= 1; q--) if (!cov[(q - 1) * 3 + int'(m) - 1]) p = 2'(q);
            run_round(p, "judge");
            if (!cov[(int'(p) - 1) * 3 + int'(m) - 1]) covered++;
            cov[(int'(p) - 1) * 3 + int'(m) - 1] = 1'b1;
        end
        checks++;
        if (covered != 9) begin failures++; $display("FAIL judge_coverage: got %0d combos want 9", covered); end
    endtask
    task automatic test_invalid();
        logic [1:0] pm0;
        int busy_seen, rv_wait;
        pm0 = bus.player_move;
        busy_seen = 0;
        set_btn(3'b011);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) set_btn(3'b000);
            if (bus.busy) busy_seen++;
        end
        checks += 2;
        if (busy_seen != 0) begin failures++; $display("FAIL dual_press busy: got %0d busy cycles want 0", busy_seen); end
        if (bus.player_move !== pm0) begin failures++; $display("FAIL dual_press player_move: got %0d want %0d", bus.player_move, pm0); end
        set_btn(3'b001);
        @(negedge clk) set_btn(3'b010);
        @(negedge clk) set_btn(3'b100);
        @(negedge clk) set_btn(3'b000);
        checks += 2;
        if (bus.player_move !== 2'd1) begin failures++; $display("FAIL reveal_press player_move: got %0d want 1", bus.player_move); end
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL reveal_press busy: got %b want 1", bus.busy); end
        rv_wait = 0;
        while (!bus.result_valid && rv_wait < 10) begin
            @(negedge clk);
            rv_wait++;
        end
        checks += 2;
        if (!bus.result_valid) begin failures++; $display("FAIL reveal_press verdict: got none within 10 cycles want pulse"); end
        if (bus.player_move !== 2'd1) begin failures++; $display("FAIL reveal_press final player_move: got %0d want 1", bus.player_move); end
        repeat (2) @(negedge clk);
    endtask
    task automatic test_abort();
        int rv_n, bad;
        set_btn(3'b001);
        @(negedge clk) set_btn(3'b000);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort started busy: got %b want 1", bus.busy); end
        @(negedge clk) bus.game_active = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort busy: got %b want 0", bus.busy); end
        rv_n = 0; bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) set_btn(3'b010);
            if (k == 3) set_btn(3'b000);
            @(negedge clk);
            if (bus.result_valid) rv_n++;
            if (bus.result !== 2'b01) bad++;
            if (bus.busy) bad++;
        end
        checks += 3;
        if (rv_n != 0) begin failures++; $display("FAIL abort valid_pulses: got %0d want 0", rv_n); end
        if (bad != 0) begin failures++; $display("FAIL abort idle: got %0d bad cycles want 0", bad); end
        if (bus.machine_move !== 2'd0) begin failures++; $display("FAIL abort machine_move: got %0d want 0", bus.machine_move); end
        bus.game_active = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_reset_mid();
        set_btn(3'b001);
        for (int k = 0; k <= RC; k++) begin
            @(negedge clk);
            set_btn(3'b000);
        end
        checks += 2;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL judge busy: got %b want 1", bus.busy); end
        if (bus.machine_move === 2'd0) begin failures++; $display("FAIL judge machine_move: got 0 want nonzero"); end
        #1 reset = 1'b0;
        #1;
        checks += 5;
        if (bus.result !== 2'b01) begin failures++; $display("FAIL midreset result: got %b want 01", bus.result); end
        if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL midreset result_valid: got %b want 0", bus.result_valid); end
        if (bus.player_move !== 2'd0) begin failures++; $display("FAIL midreset player_move: got %b want 00", bus.player_move); end
        if (bus.machine_move !== 2'd0) begin failures++; $display("FAIL midreset machine_move: got %b want 00", bus.machine_move); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b want 0", bus.busy); end
        @(negedge clk) reset = 1'b1;
        run_round(2'd2, "after_reset");
    endtask
    initial begin
        reset = 1'b1;
        set_btn(3'b000);
        bus.game_active = 1'b1;
        #3 reset = 1'b0;
        test_reset();
        test_lfsr();
        test_single_round();
        test_judge_coverage();
        test_invalid();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
